// File: rtl/add_sub_arbiter.sv
// Round-robin sequencer sharing one combinational sign-magnitude add/sub unit between two requesters.
// Optional statistics counters (ops0/ops1/zeros) are enabled by defining ADDSUB_ARB_STATS_EN.
module add_sub_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [2:0]       a0,
  input  logic [2:0]       b0,
  input  logic             sel0,
  input  logic             req1,
  input  logic [2:0]       a1,
  input  logic [2:0]       b1,
  input  logic             sel1,
  output logic             done0,
  output logic             done1,
  output logic [4:0]       res,
  output logic             res_zero,
  output logic             busy,
`ifdef ADDSUB_ARB_STATS_EN
  output logic [CNT_W-1:0] ops0,
  output logic [CNT_W-1:0] ops1,
  output logic [CNT_W-1:0] zeros,
`endif
  output logic [2:0]       au_num1,
  output logic [2:0]       au_num2,
  output logic             au_sel,
  input  logic [4:0]       au_result,
  input  logic             au_zero
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  // Out-of-range settings have no meaningful hardware; this block stays empty for legal ones.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || CNT_W < 1) begin : g_illegal_params
  end

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic       gnt_q, gnt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] num1_q, num1_d;
  logic [2:0] num2_q, num2_d;
  logic       sel_q, sel_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic [4:0] res_q, res_d;
  logic       zero_q, zero_d;
  logic       win;

  // Pointed-to requester wins if requesting, otherwise the other one.
  assign win = rr_q ? req1 : ~req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= 4'd0;
      num1_q  <= 3'b000;
      num2_q  <= 3'b000;
      sel_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      res_q   <= 5'b00000;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      sel_q   <= sel_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    sel_d   = sel_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = win;
          num1_d  = win ? a1 : a0;
          num2_d  = win ? b1 : b0;
          sel_d   = win ? sel1 : sel0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = SettleLoad;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        res_d   = au_result;
        zero_d  = au_zero;
        done0_d = ~gnt_q;
        done1_d = gnt_q;
        rr_d    = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res      = res_q;
  assign res_zero = zero_q;
  assign busy     = (state_q != IDLE);
  assign au_num1  = num1_q;
  assign au_num2  = num2_q;
  assign au_sel   = sel_q;

`ifdef ADDSUB_ARB_STATS_EN
  logic [CNT_W-1:0] ops0_q, ops1_q, zeros_q;

  // Saturating counters, all advanced on the capture cycle of a transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops0_q  <= '0;
      ops1_q  <= '0;
      zeros_q <= '0;
    end else if (state_q == CAPTURE) begin
      if (!gnt_q && ops0_q != '1) begin
        ops0_q <= ops0_q + CNT_W'(1);
      end
      if (gnt_q && ops1_q != '1) begin
        ops1_q <= ops1_q + CNT_W'(1);
      end
      if (au_zero && zeros_q != '1) begin
        zeros_q <= zeros_q + CNT_W'(1);
      end
    end
  end

  assign ops0  = ops0_q;
  assign ops1  = ops1_q;
  assign zeros = zeros_q;
`endif

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Self-checking bench for add_sub_arbiter: transaction-level model plus directed vectors.
// Stats checks run only when ADDSUB_ARB_STATS_EN is defined.
module tb_add_sub_arbiter;

  localparam int Settle  = 2;
  localparam int CntW    = 8;
  localparam int Latency = Settle + 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0  = 1'b0;
  logic [2:0] a0    = 3'b000;
  logic [2:0] b0    = 3'b000;
  logic       sel0  = 1'b0;
  logic       req1  = 1'b0;
  logic [2:0] a1    = 3'b000;
  logic [2:0] b1    = 3'b000;
  logic       sel1  = 1'b0;
  logic       done0, done1, resZero, busy, auSel, auZero;
  logic [4:0] res, auResult;
  logic [2:0] auNum1, auNum2;
  logic [5:0] unitOut;
`ifdef ADDSUB_ARB_STATS_EN
  logic [CntW-1:0] ops0, ops1, zeros;
`endif

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  add_sub_arbiter #(.SETTLE_CYCLES(Settle), .CNT_W(CntW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .sel0(sel0),
    .req1(req1), .a1(a1), .b1(b1), .sel1(sel1),
    .done0(done0), .done1(done1), .res(res), .res_zero(resZero), .busy(busy),
`ifdef ADDSUB_ARB_STATS_EN
    .ops0(ops0), .ops1(ops1), .zeros(zeros),
`endif
    .au_num1(auNum1), .au_num2(auNum2), .au_sel(auSel),
    .au_result(auResult), .au_zero(auZero)
  );

  always #5 clk = ~clk;

  // Sign-magnitude add/sub: returns {sign, 0, magnitude[2:0], zero}; negative zero reads as +0.
  function automatic logic [5:0] unitCalc(input logic [2:0] x, input logic [2:0] y, input logic s);
    int vx, vy, r, m;
    vx = x[2] ? -int'(x[1:0]) : int'(x[1:0]);
    vy = y[2] ? -int'(y[1:0]) : int'(y[1:0]);
    r  = s ? vx - vy : vx + vy;
    m  = (r < 0) ? -r : r;
    return {(r < 0), 1'b0, 3'(m), (r == 0)};
  endfunction

  assign unitOut  = unitCalc(auNum1, auNum2, auSel);
  assign auResult = unitOut[5:1];
  assign auZero   = unitOut[0];

  // Transaction model: a grant keeps the arbiter busy for Settle+2 cycles, then done pulses once.
  int         mLeft = 0;
  logic       mRr = 1'b0, mGnt = 1'b0, mSel = 1'b0, mWin;
  logic [2:0] mA = 3'b000, mB = 3'b000;
  logic       expDone0 = 1'b0, expDone1 = 1'b0, expZero = 1'b0;
  logic [4:0] expRes = 5'b00000;

  assign mWin = mRr ? req1 : !req0;

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      mLeft <= 0; mRr <= 1'b0; mGnt <= 1'b0; mA <= 3'b000; mB <= 3'b000; mSel <= 1'b0;
      expDone0 <= 1'b0; expDone1 <= 1'b0; expRes <= 5'b00000; expZero <= 1'b0;
    end else begin
      expDone0 <= 1'b0;
      expDone1 <= 1'b0;
      if (mLeft > 0) begin
        mLeft <= mLeft - 1;
        if (mLeft == 1) begin
          {expRes, expZero} <= unitCalc(mA, mB, mSel);
          if (mGnt) expDone1 <= 1'b1; else expDone0 <= 1'b1;
          mRr <= !mGnt;
        end
      end else if (req0 || req1) begin
        mGnt  <= mWin;
        mA    <= mWin ? a1 : a0;
        mB    <= mWin ? b1 : b0;
        mSel  <= mWin ? sel1 : sel0;
        mLeft <= Settle + 2;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("done0", done0, expDone0);
      checkOutput("done1", done1, expDone1);
      checkOutput("busy", busy, (mLeft > 0));
      checkOutput("res", res, expRes);
      checkOutput("resZero", resZero, expZero);
      checkOutput("auNum1", auNum1, mA);
      checkOutput("auNum2", auNum2, mB);
      checkOutput("auSel", auSel, mSel);
    end
  end

  task automatic applyStimulus(input bit id, input logic [2:0] a, input logic [2:0] b,
                               input logic s, input logic r);
    if (id) begin a1 = a; b1 = b; sel1 = s; req1 = r; end
    else    begin a0 = a; b0 = b; sel0 = s; req0 = r; end
  endtask

  task automatic waitDone(output int id, output int cycles, output bit ok);
    ok = 1'b0; id = -1; cycles = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (done0 || done1) begin
        ok = 1'b1;
        id = done1 ? 1 : 0;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL doneTimeout: no done after %0d cycles, required within 40", cycles);
    end
  endtask

  typedef struct {
    bit         id;
    logic [2:0] a, b;
    logic       s;
    logic [4:0] r;
    logic       z;
  } vec_t;

  vec_t vecs [5];

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int  id, cyc;
    bit  ok;
    vecs = '{'{1'b1, 3'b101, 3'b001, 1'b0, 5'b00000, 1'b1},
             '{1'b0, 3'b110, 3'b011, 1'b1, 5'b10101, 1'b0},
             '{1'b1, 3'b111, 3'b111, 1'b1, 5'b00000, 1'b1},
             '{1'b0, 3'b011, 3'b111, 1'b1, 5'b00110, 1'b0},
             '{1'b1, 3'b100, 3'b000, 1'b0, 5'b00000, 1'b1}};

    repeat (3) @(posedge clk);
    #1 checkEn = 1'b1;
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstRes", res, 5'b00000);
    checkOutput("rstAuNum1", auNum1, 3'b000);
    checkOutput("rstDone0", done0, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;

    $display("[TB] req0 only: 3 + 2");
    @(posedge clk); #1 applyStimulus(0, 3'b011, 3'b010, 1'b0, 1'b1);
    waitDone(id, cyc, ok);
    checkOutput("t1Latency", 8'(cyc), 8'(Latency));
    checkOutput("t1Id", 8'(id), 8'd0);
    checkOutput("t1Res", res, 5'b00101);
    checkOutput("t1Zero", resZero, 1'b0);
    checkOutput("t1AuNum1", auNum1, 3'b011);
    checkOutput("t1AuNum2", auNum2, 3'b010);
    applyStimulus(0, 3'b011, 3'b010, 1'b0, 1'b0);

    $display("[TB] req1 only: 1 - 1");
    @(posedge clk); #1 applyStimulus(1, 3'b001, 3'b001, 1'b1, 1'b1);
    waitDone(id, cyc, ok);
    checkOutput("t2Latency", 8'(cyc), 8'(Latency));
    checkOutput("t2Id", 8'(id), 8'd1);
    checkOutput("t2Res", res, 5'b00000);
    checkOutput("t2Zero", resZero, 1'b1);
    checkOutput("t2Done0", done0, 1'b0);
    applyStimulus(1, 3'b001, 3'b001, 1'b1, 1'b0);

    $display("[TB] simultaneous back-to-back traffic");
    @(posedge clk); #1;
    applyStimulus(0, 3'b010, 3'b001, 1'b1, 1'b1);
    applyStimulus(1, 3'b101, 3'b010, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      waitDone(id, cyc, ok);
      if (!ok) break;
      checkOutput("t3Order", 8'(id), 8'(k % 2));
      if (k == 7) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end else begin
        applyStimulus(id[0], 3'(k), 3'b001, 1'b0, 1'b0);
        @(posedge clk); #1;
        applyStimulus(id[0], 3'(k), 3'b001, 1'b0, 1'b1);
      end
    end

    $display("[TB] operand change after grant");
    @(posedge clk); #1 applyStimulus(0, 3'b011, 3'b010, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 a0 = 3'b111;
    waitDone(id, cyc, ok);
    checkOutput("t4Id", 8'(id), 8'd0);
    checkOutput("t4AuNum1", auNum1, 3'b011);
    checkOutput("t4Res", res, 5'b00101);
    req0 = 1'b0;

    $display("[TB] reset during settle");
    @(posedge clk); #1 applyStimulus(0, 3'b001, 3'b110, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 checkOutput("t5BusyBefore", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5Busy", busy, 1'b0);
    checkOutput("t5Done0", done0, 1'b0);
    checkOutput("t5Res", res, 5'b00000);
    checkOutput("t5AuNum1", auNum1, 3'b000);
    checkOutput("t5AuNum2", auNum2, 3'b000);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    waitDone(id, cyc, ok);
    checkOutput("t5Latency", 8'(cyc), 8'(Latency));
    checkOutput("t5Id", 8'(id), 8'd0);
    checkOutput("t5ResAfter", res, 5'b10001);
    checkOutput("t5ZeroAfter", resZero, 1'b0);
    req0 = 1'b0;

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      @(posedge clk); #1 applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].s, 1'b1);
      waitDone(id, cyc, ok);
      checkOutput("t6Id", 8'(id), 8'(vecs[i].id));
      checkOutput("t6Res", res, vecs[i].r);
      checkOutput("t6Zero", resZero, vecs[i].z);
      applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].s, 1'b0);
    end

`ifdef ADDSUB_ARB_STATS_EN
    $display("[TB] statistics saturation");
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (i == 7 || i == 150 || i == 299) applyStimulus(0, 3'b001, 3'b001, 1'b1, 1'b1);
      else applyStimulus(0, 3'b010, 3'b001, 1'b0, 1'b1);
      waitDone(id, cyc, ok);
      req0 = 1'b0;
      if (!ok) break;
    end
    @(posedge clk); #1;
    checkOutput("statOps0", ops0, 8'd255);
    checkOutput("statOps1", ops1, 8'd0);
    checkOutput("statZeros", zeros, 8'd3);
`endif

    repeat (3) @(posedge clk);
    #1 checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
